// File: rtl/ibex_avalon_mem_arbiter.sv
// rtl/ibex_avalon_mem_arbiter.sv - ibex instr/data ports shared onto one Avalon-MM master
// Round-robin arbitration, command hold under waitrequest, in-order read routing via owner FIFO.
module ibex_avalon_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic [1:0]  avm_response,
  output logic        protocol_err_o
);

  localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MaxOutstanding);
  localparam logic [PW-1:0] LAST_PTR = PW'(MaxOutstanding - 1);

  logic          r_lock;
  logic          r_lock_src;
  logic          r_rr;
  logic          r_fifo [MaxOutstanding];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_wr_pend;
  logic          r_instr_rvalid;
  logic [31:0]   r_instr_rdata;
  logic          r_instr_err;
  logic          r_data_rvalid;
  logic [31:0]   r_data_rdata;
  logic          r_data_err;
  logic          r_proto_err;

  logic          w_pop;
  logic          w_room;
  logic          w_instr_ok;
  logic          w_data_ok;
  logic          w_pref;
  logic          w_sel_src;
  logic          w_sel_valid;
  logic          w_cmd;
  logic          w_sel_we;
  logic [31:0]   w_sel_addr;
  logic          w_accept;
  logic          w_push;
  logic          w_head;

  // A draining response frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_pop      = avm_readdatavalid & (r_cnt != '0);
  assign w_room     = (r_cnt < MAX_CNT) | w_pop;
  assign w_instr_ok = instr_req_i & w_room;
  assign w_data_ok  = data_req_i & (data_we_i ? ((r_cnt == '0) & ~r_wr_pend) : w_room);
  assign w_pref     = (instr_req_i & data_req_i) ? ~r_rr : data_req_i;

  always_comb begin
    w_sel_src   = 1'b0;
    w_sel_valid = 1'b0;
    if (r_lock) begin
      w_sel_src   = r_lock_src;
      w_sel_valid = r_lock_src ? data_req_i : instr_req_i;
    end else if (w_pref ? w_data_ok : w_instr_ok) begin
      w_sel_src   = w_pref;
      w_sel_valid = 1'b1;
    end else if (w_pref ? w_instr_ok : w_data_ok) begin
      w_sel_src   = ~w_pref;
      w_sel_valid = 1'b1;
    end
  end

  assign w_cmd      = w_sel_valid & rst_ni;
  assign w_sel_we   = w_sel_src & data_we_i;
  assign w_sel_addr = w_sel_src ? data_addr_i : instr_addr_i;
  assign w_accept   = w_cmd & ~avm_waitrequest;
  assign w_push     = w_accept & ~w_sel_we;
  assign w_head     = r_fifo[r_rptr];

  assign avm_address    = w_sel_addr & 32'hFFFF_FFFC;
  assign avm_byteenable = w_sel_src ? data_be_i : 4'hF;
  assign avm_read       = w_cmd & ~w_sel_we;
  assign avm_write      = w_cmd & w_sel_we;
  assign avm_writedata  = data_wdata_i;

  assign instr_gnt_o    = w_accept & ~w_sel_src;
  assign data_gnt_o     = w_accept & w_sel_src;
  assign instr_rvalid_o = r_instr_rvalid;
  assign instr_rdata_o  = r_instr_rdata;
  assign instr_err_o    = r_instr_err;
  assign data_rvalid_o  = r_data_rvalid;
  assign data_rdata_o   = r_data_rdata;
  assign data_err_o     = r_data_err;
  assign protocol_err_o = r_proto_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock         <= 1'b0;
      r_lock_src     <= 1'b0;
      r_rr           <= 1'b1;
      for (int i = 0; i < MaxOutstanding; i++) r_fifo[i] <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_cnt          <= '0;
      r_wr_pend      <= 1'b0;
      r_instr_rvalid <= 1'b0;
      r_instr_rdata  <= '0;
      r_instr_err    <= 1'b0;
      r_data_rvalid  <= 1'b0;
      r_data_rdata   <= '0;
      r_data_err     <= 1'b0;
      r_proto_err    <= 1'b0;
    end else begin
      if (w_cmd & avm_waitrequest) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_sel_src;
      end else if (w_accept) begin
        r_lock     <= 1'b0;
      end
      if (w_accept) r_rr <= w_sel_src;

      if (w_push) begin
        r_fifo[r_wptr] <= w_sel_src;
        r_wptr         <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase

      // Write response is synthesised locally one cycle after acceptance.
      r_wr_pend      <= w_accept & w_sel_we;
      r_instr_rvalid <= w_pop & ~w_head;
      r_data_rvalid  <= (w_pop & w_head) | (w_accept & w_sel_we);
      if (w_pop) begin
        if (w_head) begin
          r_data_rdata  <= avm_readdata;
          r_data_err    <= |avm_response;
        end else begin
          r_instr_rdata <= avm_readdata;
          r_instr_err   <= |avm_response;
        end
      end else if (w_accept & w_sel_we) begin
        r_data_rdata <= '0;
        r_data_err   <= 1'b0;
      end

      if (avm_readdatavalid && (r_cnt == '0)) r_proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_avalon_mem_arbiter.sv
// tb/tb_ibex_avalon_mem_arbiter.sv - directed bench for ibex_avalon_mem_arbiter
module tb_ibex_avalon_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic [31:0] avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [1:0]  avm_response;
  logic        protocol_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  ibex_avalon_mem_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_response(avm_response),
    .protocol_err_o(protocol_err_o)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic        wreq;
    logic        e_igt;
    logic        e_dgt;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    avm_waitrequest = 0; avm_readdata = 0; avm_readdatavalid = 0; avm_response = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int ngnt;
  int gcyc [3];

  initial begin
    //            ireq iaddr          dreq dwe be    daddr          wait igt dgt rd wr addr           be
    vecs[0] = '{1, 32'h0000_1006, 0, 0, 4'h0, 32'h0,         0, 1, 0, 1, 0, 32'h0000_1004, 4'hF};
    vecs[1] = '{0, 32'h0,         1, 0, 4'h3, 32'h0000_2003, 0, 0, 1, 1, 0, 32'h0000_2000, 4'h3};
    vecs[2] = '{0, 32'h0,         1, 1, 4'hC, 32'h0000_3008, 0, 0, 1, 0, 1, 32'h0000_3008, 4'hC};
    vecs[3] = '{1, 32'h0000_1006, 1, 0, 4'h1, 32'h0000_2000, 0, 1, 0, 1, 0, 32'h0000_1004, 4'hF};
    vecs[4] = '{1, 32'h0000_1006, 1, 0, 4'h1, 32'h0000_2000, 1, 0, 0, 1, 0, 32'h0000_1004, 4'hF};
    vecs[5] = '{0, 32'h0000_1006, 0, 0, 4'h1, 32'h0000_2000, 0, 0, 0, 0, 0, 32'h0,         4'h0};
    vecs[6] = '{0, 32'h0,         1, 1, 4'h6, 32'h0000_4001, 1, 0, 0, 0, 1, 32'h0000_4000, 4'h6};
    vecs[7] = '{1, 32'h0000_0F0A, 1, 1, 4'hF, 32'h0000_5000, 0, 1, 0, 1, 0, 32'h0000_0F08, 4'hF};

    // Reset state
    do_reset();
    @(negedge clk_i);
    chk("rst_igt", instr_gnt_o, 0);   chk("rst_dgt", data_gnt_o, 0);
    chk("rst_irv", instr_rvalid_o, 0); chk("rst_drv", data_rvalid_o, 0);
    chk("rst_ird", instr_rdata_o, 0); chk("rst_drd", data_rdata_o, 0);
    chk("rst_ierr", instr_err_o, 0);  chk("rst_derr", data_err_o, 0);
    chk("rst_rd", avm_read, 0);       chk("rst_wr", avm_write, 0);
    chk("rst_perr", protocol_err_o, 0);

    // Table: selection and command from the reset state
    for (int v = 0; v < 8; v++) begin
      do_reset();
      instr_req_i = vecs[v].ireq; instr_addr_i = vecs[v].iaddr;
      data_req_i = vecs[v].dreq; data_we_i = vecs[v].dwe; data_be_i = vecs[v].dbe;
      data_addr_i = vecs[v].daddr; data_wdata_i = 32'hA5A5_0000 | v;
      avm_waitrequest = vecs[v].wreq;
      @(negedge clk_i);
      chk($sformatf("v%0d_igt", v), instr_gnt_o, vecs[v].e_igt);
      chk($sformatf("v%0d_dgt", v), data_gnt_o, vecs[v].e_dgt);
      chk($sformatf("v%0d_rd", v), avm_read, vecs[v].e_rd);
      chk($sformatf("v%0d_wr", v), avm_write, vecs[v].e_wr);
      if (vecs[v].e_rd || vecs[v].e_wr) begin
        chk($sformatf("v%0d_addr", v), avm_address, vecs[v].e_addr);
        chk($sformatf("v%0d_be", v), avm_byteenable, vecs[v].e_be);
      end
      if (vecs[v].e_wr) chk($sformatf("v%0d_wdata", v), avm_writedata, 32'hA5A5_0000 | v);
    end

    // Single fetch
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      instr_req_i = (c == 0); instr_addr_i = 32'h0000_1006;
      avm_readdatavalid = (c == 2); avm_readdata = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk_i);
      if (c == 0) begin
        chk("sf_addr", avm_address, 32'h0000_1004);
        chk("sf_gnt", instr_gnt_o, 1);
      end
      chk($sformatf("sf_rv_c%0d", c), instr_rvalid_o, (c == 3));
      if (c == 3) begin
        chk("sf_rdata", instr_rdata_o, 32'hDEAD_BEEF);
        chk("sf_err", instr_err_o, 0);
        chk("sf_drv", data_rvalid_o, 0);
      end
    end

    // Contention: alternating grants, responses routed to owners
    do_reset();
    instr_addr_i = 32'h100; data_addr_i = 32'h200; data_be_i = 4'hF;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      instr_req_i = (c < 6); data_req_i = (c < 6);
      avm_readdatavalid = (c >= 1 && c <= 6);
      avm_readdata = 32'h1000_0000 | c;
      @(negedge clk_i);
      if (c < 6) begin
        chk($sformatf("ct_igt_c%0d", c), instr_gnt_o, (c % 2 == 0));
        chk($sformatf("ct_dgt_c%0d", c), data_gnt_o, (c % 2 == 1));
      end
      if (c >= 2 && c <= 7) begin
        chk($sformatf("ct_irv_c%0d", c), instr_rvalid_o, ((c - 2) % 2 == 0));
        chk($sformatf("ct_drv_c%0d", c), data_rvalid_o, ((c - 2) % 2 == 1));
        if ((c - 2) % 2 == 0) chk($sformatf("ct_ird_c%0d", c), instr_rdata_o, 32'h1000_0000 | (c - 1));
        else                  chk($sformatf("ct_drd_c%0d", c), data_rdata_o, 32'h1000_0000 | (c - 1));
      end
      if (c == 8) chk("ct_idle", instr_rvalid_o | data_rvalid_o, 0);
    end

    // Waitrequest hold on a data write while instr_req rises
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      data_req_i = (c <= 3); data_we_i = 1; data_be_i = 4'hF;
      data_addr_i = 32'h40; data_wdata_i = 32'h1234_5678;
      avm_waitrequest = (c <= 2);
      instr_req_i = (c >= 1 && c <= 4); instr_addr_i = 32'h900;
      @(negedge clk_i);
      if (c <= 3) begin
        chk($sformatf("wh_wr_c%0d", c), avm_write, 1);
        chk($sformatf("wh_addr_c%0d", c), avm_address, 32'h40);
        chk($sformatf("wh_wd_c%0d", c), avm_writedata, 32'h1234_5678);
        chk($sformatf("wh_dgt_c%0d", c), data_gnt_o, (c == 3));
        chk($sformatf("wh_igt_c%0d", c), instr_gnt_o, 0);
      end
      if (c == 4) begin
        chk("wh_drv", data_rvalid_o, 1);
        chk("wh_derr", data_err_o, 0);
        chk("wh_igt_after", instr_gnt_o, 1);
      end
      if (c == 5) chk("wh_drv_end", data_rvalid_o, 0);
    end

    // Outstanding limit: third read waits for the first response
    do_reset();
    ngnt = 0;
    gcyc[0] = -1; gcyc[1] = -1; gcyc[2] = -1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) tick();
      instr_req_i = (ngnt < 3); instr_addr_i = 32'h10 + 4 * ngnt;
      avm_readdatavalid = (c == 5 || c == 6 || c == 11);
      avm_readdata = (c == 5) ? 32'hC0DE_0001 : (c == 6) ? 32'hC0DE_0002 : 32'hC0DE_0003;
      @(negedge clk_i);
      if (instr_gnt_o && ngnt < 3) begin
        gcyc[ngnt] = c;
        ngnt++;
      end
      if (c >= 2 && c <= 4) begin
        chk($sformatf("ol_gnt_c%0d", c), instr_gnt_o, 0);
        chk($sformatf("ol_rd_c%0d", c), avm_read, 0);
      end
      chk($sformatf("ol_rv_c%0d", c), instr_rvalid_o, (c == 6 || c == 7 || c == 12));
      if (c == 6)  chk("ol_rd1", instr_rdata_o, 32'hC0DE_0001);
      if (c == 7)  chk("ol_rd2", instr_rdata_o, 32'hC0DE_0002);
      if (c == 12) chk("ol_rd3", instr_rdata_o, 32'hC0DE_0003);
    end
    chk("ol_ngnt", ngnt, 3);
    chk("ol_g1", gcyc[0], 0);
    chk("ol_g2", gcyc[1], 1);
    chk("ol_g3_window", (gcyc[2] == 5 || gcyc[2] == 6), 1);

    // Write ordering behind two reads, error on second read
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      instr_req_i = (c <= 1); instr_addr_i = (c == 0) ? 32'h20 : 32'h24;
      data_req_i = (c >= 1 && c <= 5); data_we_i = 1; data_be_i = 4'hF;
      data_addr_i = 32'h300; data_wdata_i = 32'hCAFE_F00D;
      avm_readdatavalid = (c == 3 || c == 4);
      avm_readdata = (c == 3) ? 32'h11 : 32'h22;
      avm_response = (c == 4) ? 2'b10 : 2'b00;
      @(negedge clk_i);
      if (c <= 1) chk($sformatf("wo_igt_c%0d", c), instr_gnt_o, 1);
      if (c >= 1 && c <= 5) chk($sformatf("wo_dgt_c%0d", c), data_gnt_o, (c == 5));
      if (c == 4) begin
        chk("wo_rv1", instr_rvalid_o, 1); chk("wo_rd1", instr_rdata_o, 32'h11); chk("wo_err1", instr_err_o, 0);
      end
      if (c == 5) begin
        chk("wo_rv2", instr_rvalid_o, 1); chk("wo_rd2", instr_rdata_o, 32'h22); chk("wo_err2", instr_err_o, 1);
        chk("wo_drv5", data_rvalid_o, 0);
      end
      if (c == 6) begin
        chk("wo_drv", data_rvalid_o, 1); chk("wo_derr", data_err_o, 0); chk("wo_irv6", instr_rvalid_o, 0);
      end
    end

    // Protocol error, sticky
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      avm_readdatavalid = (c == 0); avm_readdata = 32'h77;
      @(negedge clk_i);
      if (c == 0) chk("pe_c0", protocol_err_o, 0);
      else begin
        chk($sformatf("pe_c%0d", c), protocol_err_o, 1);
        chk($sformatf("pe_rv_c%0d", c), instr_rvalid_o | data_rvalid_o, 0);
      end
    end

    // Asynchronous reset mid-burst, stale response afterwards
    do_reset();
    @(negedge clk_i);
    chk("ar_perr_clr", protocol_err_o, 0);
    tick();
    instr_req_i = 1; instr_addr_i = 32'h80;
    @(negedge clk_i);
    chk("ar_gnt", instr_gnt_o, 1);
    tick();
    instr_req_i = 0; avm_readdatavalid = 1; avm_readdata = 32'h55;
    @(negedge clk_i);
    tick();
    avm_readdatavalid = 0; instr_req_i = 1;
    @(negedge clk_i);
    chk("ar_rv_before", instr_rvalid_o, 1);
    chk("ar_rd_before", instr_rdata_o, 32'h55);
    #2 rst_ni = 0;
    #1;
    chk("ar_rv", instr_rvalid_o, 0);
    chk("ar_rd", instr_rdata_o, 0);
    chk("ar_gnt0", instr_gnt_o, 0);
    chk("ar_read0", avm_read, 0);
    chk("ar_perr0", protocol_err_o, 0);
    tick();
    rst_ni = 1; instr_req_i = 0; avm_readdatavalid = 1; avm_readdata = 32'h66;
    tick();
    avm_readdatavalid = 0;
    @(negedge clk_i);
    chk("ar_stale_perr", protocol_err_o, 1);
    chk("ar_stale_rv", instr_rvalid_o | data_rvalid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
